// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscky_pkg
// Description : Shared constants for the writeback path: default data and
//               register-index widths, default requester count and the fixed
//               requester slot numbers.
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
package riscky_pkg;

  localparam int DEF_XLEN        = 32;
  localparam int DEF_REG_SEL_LEN = 5;
  localparam int DEF_N_REQ       = 2;

  // Requester slots on the writeback port
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback request bus. It carries the flattened valid/ready
//               handshake plus destination and data for N_REQ requesters.
//               Requester i uses req_dest[i*REG_SEL_LEN +: REG_SEL_LEN] and
//               req_data[i*XLEN +: XLEN].
// Modports    : master - requester side (drives valid/dest/data)
//               slave  - arbiter side (drives ready)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int N_REQ       = riscky_pkg::DEF_N_REQ,
  parameter int XLEN        = riscky_pkg::DEF_XLEN,
  parameter int REG_SEL_LEN = riscky_pkg::DEF_REG_SEL_LEN
);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ*REG_SEL_LEN-1:0] req_dest;
  logic [N_REQ*XLEN-1:0]        req_data;

  modport master (output req_valid, output req_dest, output req_data, input req_ready);
  modport slave  (input req_valid, input req_dest, input req_data, output req_ready);

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. The grant goes to the first valid
//               requester at rr_ptr, rr_ptr+1, ... mod N_REQ. On an accept
//               strobe the pointer moves to the slot after the winner.
// Ports       : clk, reset (async, active-low), req_valid[N_REQ],
//               accept (a grant was taken this cycle), grant[N_REQ] (one-hot
//               or zero)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             accept,
  output logic [N_REQ-1:0] grant
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   w_idx;
  logic [PTR_W-1:0] w_gidx;
  logic             w_found;

  // Scan from the pointer with an explicit wrap, so non-power-of-two
  // requester counts never index past the last slot.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(N_REQ)) begin
        w_idx = w_idx - (PTR_W+1)'(N_REQ);
      end
      if (!w_found && req_valid[w_idx[PTR_W-1:0]]) begin
        grant[w_idx[PTR_W-1:0]] = 1'b1;
        w_gidx  = w_idx[PTR_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (accept) begin
      r_ptr <= (w_gidx == PTR_W'(N_REQ-1)) ? '0 : w_gidx + PTR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-file write port between N_REQ writeback
//               requesters using round-robin arbitration. It registers the
//               winning write for one cycle and keeps a busy-register
//               scoreboard for RAW stall decisions.
// Ports       : clk, reset (async, active-low)
//               wb              - request bus (slave modport)
//               issue_valid/dest - marks a destination pending
//               rf_write_enable/rf_dest/rf_data_in - registered write port
//               busy            - per-register pending-write bits
//               byp_valid/dest/data - bypass view of the write stage
//                                     (optional)
// Config      : REGFILE_WB_BYPASS_EN - adds byp_* outputs. Busy bits then
//               clear at the acceptance edge instead of the commit edge.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import riscky_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int REG_SEL_LEN = DEF_REG_SEL_LEN,
  parameter int N_REQ       = DEF_N_REQ
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_wb_arbiter_if.slave       wb,
  input  logic                      issue_valid,
  input  logic [REG_SEL_LEN-1:0]    issue_dest,
  output logic                      rf_write_enable,
  output logic [REG_SEL_LEN-1:0]    rf_dest,
  output logic [XLEN-1:0]           rf_data_in,
`ifdef REGFILE_WB_BYPASS_EN
  output logic                      byp_valid,
  output logic [REG_SEL_LEN-1:0]    byp_dest,
  output logic [XLEN-1:0]           byp_data,
`endif
  output logic [(1<<REG_SEL_LEN)-1:0] busy
);

  localparam int NREG = 1 << REG_SEL_LEN;
  localparam logic [NREG-1:0] C_X0_MASK = NREG'(1);

  logic [N_REQ-1:0]       w_grant;
  logic                   w_accept;
  logic [REG_SEL_LEN-1:0] w_sel_dest;
  logic [XLEN-1:0]        w_sel_data;
  logic [NREG-1:0]        w_set;
  logic [NREG-1:0]        w_clr;

  logic                   r_we;
  logic [REG_SEL_LEN-1:0] r_dest;
  logic [XLEN-1:0]        r_data;
  logic [NREG-1:0]        r_busy;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (wb.req_valid),
    .accept    (w_accept),
    .grant     (w_grant)
  );

  assign wb.req_ready = w_grant;
  assign w_accept     = |(wb.req_valid & w_grant);

  // Grant is one-hot, so OR-ing the masked lanes selects the winner.
  always_comb begin
    w_sel_dest = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_dest = w_sel_dest | wb.req_dest[i*REG_SEL_LEN +: REG_SEL_LEN];
        w_sel_data = w_sel_data | wb.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are accepted and consume a turn, but never raise the enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_accept && (w_sel_dest != '0);
      if (w_accept) begin
        r_dest <= w_sel_dest;
        r_data <= w_sel_data;
      end
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid) begin
      w_set[issue_dest] = 1'b1;
    end
`ifdef REGFILE_WB_BYPASS_EN
    if (w_accept) begin
      w_clr[w_sel_dest] = 1'b1;
    end
`else
    if (r_we) begin
      w_clr[r_dest] = 1'b1;
    end
`endif
  end

  // Set is applied after clear: a newer producer keeps the register busy.
  // Bit 0 is forced low, which also discards x0 issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~C_X0_MASK;
    end
  end

  assign rf_write_enable = r_we;
  assign rf_dest         = r_dest;
  assign rf_data_in      = r_data;
  assign busy            = r_busy;

`ifdef REGFILE_WB_BYPASS_EN
  assign byp_valid = r_we;
  assign byp_dest  = r_dest;
  assign byp_data  = r_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A reference model
//               predicts grants and busy bits. Expected writes are queued at
//               acceptance and popped when the write stage is active.
// Config      : REGFILE_WB_BYPASS_EN (follows the DUT build)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  import riscky_pkg::*;

  localparam int XLEN = DEF_XLEN;
  localparam int RS   = DEF_REG_SEL_LEN;
  localparam int N    = DEF_N_REQ;
  localparam int NREG = 1 << RS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            issue_valid;
  logic [RS-1:0]   issue_dest;
  logic            rf_write_enable;
  logic [RS-1:0]   rf_dest;
  logic [XLEN-1:0] rf_data_in;
  logic [NREG-1:0] busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic            byp_valid;
  logic [RS-1:0]   byp_dest;
  logic [XLEN-1:0] byp_data;
`endif

  regfile_wb_arbiter_if #(.N_REQ(N), .XLEN(XLEN), .REG_SEL_LEN(RS)) wbif ();

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_SEL_LEN(RS), .N_REQ(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .wb              (wbif.slave),
    .issue_valid     (issue_valid),
    .issue_dest      (issue_dest),
    .rf_write_enable (rf_write_enable),
    .rf_dest         (rf_dest),
    .rf_data_in      (rf_data_in),
`ifdef REGFILE_WB_BYPASS_EN
    .byp_valid       (byp_valid),
    .byp_dest        (byp_dest),
    .byp_data        (byp_data),
`endif
    .busy            (busy)
  );

  typedef struct packed {
    logic [RS-1:0]   dest;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference model state
  int              m_ptr;
  logic            m_we;
  logic [NREG-1:0] m_busy;
  logic            m_hold;
  logic [RS-1:0]   m_ldest;
  logic [XLEN-1:0] m_ldata;
  logic [N-1:0]    m_gnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_busy = '0;
    m_hold = 1'b0;
    m_gnt  = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [RS-1:0] d, input logic [XLEN-1:0] x);
    wbif.req_valid[i]           = v;
    wbif.req_dest[i*RS +: RS]   = d;
    wbif.req_data[i*XLEN +: XLEN] = x;
  endtask

  // Check outputs mid-cycle, advance the model across the next edge, then
  // return just after that edge so the caller can drive the next inputs.
  task automatic cycle();
    logic [N-1:0]    g;
    logic            acc;
    int              gi;
    int              idx;
    logic [RS-1:0]   d;
    logic [XLEN-1:0] x;
    logic [NREG-1:0] clr;
    logic [NREG-1:0] set;
    wr_t             e;
    @(negedge clk);
    clr = '0;
    set = '0;
    check("rf_we", rf_write_enable, m_we);
`ifdef REGFILE_WB_BYPASS_EN
    check("byp_valid", byp_valid, m_we);
`endif
    if (m_we) begin
      if (exp_q.size() == 0) begin
        check("queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rf_dest", rf_dest, e.dest);
        check("rf_data", rf_data_in, e.data);
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_dest", byp_dest, e.dest);
        check("byp_data", byp_data, e.data);
`else
        clr[e.dest] = 1'b1;
`endif
      end
    end else if (m_hold) begin
      check("hold_dest", rf_dest, m_ldest);
      check("hold_data", rf_data_in, m_ldata);
    end
    check("busy", busy, m_busy);

    g   = '0;
    acc = 1'b0;
    gi  = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (!acc && wbif.req_valid[idx]) begin
        g[idx] = 1'b1;
        acc    = 1'b1;
        gi     = idx;
      end
    end
    check("req_ready", wbif.req_ready, g);
    m_gnt = g;

    if (acc) begin
      d = wbif.req_dest[gi*RS +: RS];
      x = wbif.req_data[gi*XLEN +: XLEN];
      m_ptr = (gi == N-1) ? 0 : gi + 1;
      if (d != '0) begin
        exp_q.push_back('{dest: d, data: x});
        m_hold  = 1'b1;
        m_ldest = d;
        m_ldata = x;
`ifdef REGFILE_WB_BYPASS_EN
        clr[d] = 1'b1;
`endif
      end else begin
        m_hold = 1'b0;
      end
    end
    if (issue_valid) set[issue_dest] = 1'b1;
    m_busy    = (m_busy & ~clr) | set;
    m_busy[0] = 1'b0;
    m_we      = acc && (d != '0);
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
  endtask

  // Asynchronous reset pulse between edges
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_we", rf_write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_dest", rf_dest, 0);
    check("rst_data", rf_data_in, 0);
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    issue_valid    = 1'b0;
    issue_dest     = '0;
    wbif.req_valid = '0;
    wbif.req_dest  = '0;
    wbif.req_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single ALU write
    set_req(REQ_ALU, 1'b1, 5, 32'hDEADBEEF);
    cycle();
    drop_all();
    cycle();
    cycle();

    // Continuous contention from reset: strict alternation
    do_reset();
    set_req(REQ_ALU, 1'b1, 3, 32'h0000_0333);
    set_req(REQ_LSU, 1'b1, 4, 32'h0000_0444);
    repeat (4) cycle();
    drop_all();
    cycle();
    cycle();

    // Scoreboard set by issue, cleared by the LSU write to r7
    issue_valid = 1'b1;
    issue_dest  = 7;
    cycle();
    issue_valid = 1'b0;
    cycle();
    cycle();
    check("busy7_pending", busy[7], 1);
    set_req(REQ_LSU, 1'b1, 7, 32'hCAFE_0007);
    cycle();
    drop_all();
    cycle();
    cycle();
    check("busy7_cleared", busy[7], 0);

    // Re-issue to r7 in the commit cycle of a write to r7: set wins
    issue_valid = 1'b1;
    issue_dest  = 7;
    cycle();
    issue_valid = 1'b0;
    set_req(REQ_ALU, 1'b1, 7, 32'h7777_0001);
    cycle();
    drop_all();
    issue_valid = 1'b1;
    issue_dest  = 7;
    cycle();
    issue_valid = 1'b0;
    cycle();
    check("busy7_set_wins", busy[7], 1);

    // x0 write and x0 issue
    set_req(REQ_ALU, 1'b1, 0, 32'h0000_1234);
    issue_valid = 1'b1;
    issue_dest  = 0;
    cycle();
    issue_valid = 1'b0;
    drop_all();
    cycle();
    set_req(REQ_ALU, 1'b1, 9, 32'h0000_0909);
    set_req(REQ_LSU, 1'b1, 10, 32'h0000_0A0A);
    cycle();
    drop_all();
    cycle();
    cycle();

    // Reset mid-stream after an accepted write, pointer left at 1
    issue_valid = 1'b1;
    issue_dest  = 12;
    cycle();
    issue_valid = 1'b0;
    set_req(REQ_ALU, 1'b1, 6, 32'h0606_0606);
    cycle();
    drop_all();
    do_reset();
    set_req(REQ_ALU, 1'b1, 11, 32'h1111_0000);
    set_req(REQ_LSU, 1'b1, 13, 32'h1313_0000);
    cycle();
    drop_all();
    cycle();
    cycle();

    // Random traffic: requesters hold until granted
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!wbif.req_valid[i] || m_gnt[i]) begin
          set_req(i, ($urandom_range(0, 2) != 0), RS'($urandom_range(0, NREG-1)), $urandom);
        end
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_dest  = RS'($urandom_range(0, NREG-1));
      cycle();
    end
    drop_all();
    issue_valid = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
